// File: rtl/fp32_pool_reduce_pkg.sv
// Shared definitions for the fp32 pooling reducer: the quiet-NaN output
// pattern, the pooling mode encoding and fp32 ordering helpers.
// Optional argmax tracking is enabled with FP32_POOL_ARGMAX_EN.
package fp32_pool_pkg;

    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic {
        MODE_MAX = 1'b0,
        MODE_MIN = 1'b1
    } pool_mode_e;

    // Exponent all ones with a non-zero mantissa.
    function automatic logic fp32_is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != '0);
    endfunction

    // Strict a < b in sign-magnitude order; +0 and -0 are equal.
    // NaNs are not ordered here, the caller tracks them separately.
    function automatic logic fp32_lt(input logic [31:0] a, input logic [31:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[30:0] == '0);
        b_zero = (b[30:0] == '0);
        if (a_zero && b_zero) begin
            return 1'b0;
        end
        if (a[31] != b[31]) begin
            return a[31];
        end
        if (a[31]) begin
            return a[30:0] > b[30:0];
        end
        return a[30:0] < b[30:0];
    endfunction

endpackage

// File: rtl/fp32_pool_reduce_if.sv
// Stream interface of the fp32 pooling reducer: element input handshake,
// result output handshake and per-window mode select.
// out_index exists only when FP32_POOL_ARGMAX_EN is defined.
interface fp32_pool_reduce_if #(
    parameter int unsigned CNT_W = 4
);
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_nan;
`ifdef FP32_POOL_ARGMAX_EN
    logic [CNT_W-1:0] out_index;

    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_nan, out_index
    );

    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_nan, out_index
    );
`else
    modport master (
        output mode, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_nan
    );

    modport slave (
        input  mode, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_nan
    );
`endif
endinterface

// File: rtl/fp32_pool_reduce_cmp_sel.sv
// Combinational fp32 compare-select: picks the better of the current and
// new value under the given mode. Ties keep the current (earlier) value.
module fp32_cmp_sel
    import fp32_pool_pkg::*;
(
    input  logic [31:0] cur_i,
    input  logic [31:0] new_i,
    input  logic        mode_i,
    output logic [31:0] sel_o,
    output logic        take_new_o
);

    // Strict comparison so that equal values never displace the earlier one.
    always_comb begin
        if (mode_i == MODE_MIN) begin
            take_new_o = fp32_lt(new_i, cur_i);
        end else begin
            take_new_o = fp32_lt(cur_i, new_i);
        end
        sel_o = take_new_o ? new_i : cur_i;
    end

endmodule

// File: rtl/fp32_pool_reduce.sv
// Streaming fp32 pooling reducer: folds up to WINDOW elements (or fewer,
// closed by in_last) into their max or min and emits one registered result
// per window with backpressure. Any NaN in a window yields the quiet NaN.
// Define FP32_POOL_ARGMAX_EN to add out_index (position of the selection).
module fp32_pool_reduce
    import fp32_pool_pkg::*;
#(
    parameter int unsigned WINDOW = 9
) (
    input logic               clk,
    input logic               rst,
    fp32_pool_reduce_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    // Window accumulator state
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pool_mode_e       mode_q, mode_d;
    logic             nan_q, nan_d;

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_nan_q, out_nan_d;

`ifdef FP32_POOL_ARGMAX_EN
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] out_index_q, out_index_d;
    logic [CNT_W-1:0] merged_idx;
`endif

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic             first;
    logic             close;
    logic             new_nan;
    logic             merged_nan;
    logic [31:0]      merged;
    logic [31:0]      sel_val;
    logic             take_new;
    pool_mode_e       win_mode;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign first    = (cnt_q == '0);
    assign close    = (cnt_q == LAST_CNT) || bus.in_last;
    assign new_nan  = fp32_is_nan(bus.in_data);
    assign win_mode = first ? pool_mode_e'(bus.mode) : mode_q;

    fp32_cmp_sel u_cmp_sel (
        .cur_i      (acc_q),
        .new_i      (bus.in_data),
        .mode_i     (mode_q),
        .sel_o      (sel_val),
        .take_new_o (take_new)
    );

    // Fold the incoming element into the running window result.
    always_comb begin
        merged     = first ? bus.in_data : sel_val;
        merged_nan = (!first && nan_q) || new_nan;
`ifdef FP32_POOL_ARGMAX_EN
        // Once a NaN is seen the index freezes on the first NaN.
        if (first) begin
            merged_idx = '0;
        end else if (nan_q) begin
            merged_idx = idx_q;
        end else if (new_nan || take_new) begin
            merged_idx = cnt_q;
        end else begin
            merged_idx = idx_q;
        end
`endif
    end

    // Next-state for the accumulator and the output register.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        nan_d       = nan_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_nan_d   = out_nan_q;
`ifdef FP32_POOL_ARGMAX_EN
        idx_d       = idx_q;
        out_index_d = out_index_q;
`endif

        if (in_fire) begin
            acc_d  = merged;
            nan_d  = merged_nan;
            mode_d = win_mode;
            cnt_d  = close ? '0 : cnt_q + CNT_W'(1);
`ifdef FP32_POOL_ARGMAX_EN
            idx_d  = merged_idx;
`endif
        end

        // A close wins over a concurrent output transfer: the new result
        // replaces the departing one and out_valid stays high.
        if (in_fire && close) begin
            out_valid_d = 1'b1;
            out_data_d  = merged_nan ? FP32_QNAN : merged;
            out_count_d = cnt_q + CNT_W'(1);
            out_nan_d   = merged_nan;
`ifdef FP32_POOL_ARGMAX_EN
            out_index_d = merged_idx;
`endif
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= MODE_MAX;
            nan_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_nan_q   <= 1'b0;
`ifdef FP32_POOL_ARGMAX_EN
            idx_q       <= '0;
            out_index_q <= '0;
`endif
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            nan_q       <= nan_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_nan_q   <= out_nan_d;
`ifdef FP32_POOL_ARGMAX_EN
            idx_q       <= idx_d;
            out_index_q <= out_index_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_nan   = out_nan_q;
`ifdef FP32_POOL_ARGMAX_EN
    assign bus.out_index = out_index_q;
`endif

endmodule
